discharge_pulse_timer: RTL

- Upstream of the current-setpoint generator. Sequences one EDM discharge pulse at a time: wait for gap breakdown, time Ton, then enforce Toff.
- Drives timer_buck_interleave, which the setpoint generator uses to shape i_set.
  - 0 means no discharge.
  - 1..Ton_timer means discharge in progress.
  - Reaching Ton_timer ends the discharge.
- Also flags open-circuit timeouts and counts completed pulses.

---
 rtl/discharge_pulse_timer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/discharge_pulse_timer.sv
// discharge_pulse_timer
// Sequences one EDM discharge pulse at a time. The block waits for gap
// breakdown, times the on-period, then enforces the off-period before it
// re-arms. The running discharge timer is handed to the current-setpoint
// generator, which uses it to shape i_set.
//
// Ports
//   clk                   system clock; every time value is in clk cycles
//   rst                   synchronous, active-high reset
//   enable                machining enable (level)
//   Ton_timer             discharge on-time, latched when a pulse is armed
//   Toff_timer            off-time after a pulse or timeout (0 acts as 1)
//   wait_timeout          breakdown wait limit, 0 = wait forever
//   breakdown             gap breakdown detected (already synchronised)
//   timer_buck_interleave 0 = no discharge, 1..Ton = discharge in progress
//   is_discharging        high while in ON
//   pulse_done            one-cycle strobe in the first OFF cycle after a full pulse
//   open_circuit          one-cycle strobe in the first OFF cycle after a wait timeout
//   state_out             current state: IDLE=0, WAIT=1, ON=2, OFF=3
//   pulse_count           completed pulses, wraps modulo 2^PCNT_W
module discharge_pulse_timer #(
    parameter int CNT_W  = 32,
    parameter int PCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  Ton_timer,
    input  logic [CNT_W-1:0]  Toff_timer,
    input  logic [CNT_W-1:0]  wait_timeout,
    input  logic              breakdown,
    output logic [CNT_W-1:0]  timer_buck_interleave,
    output logic              is_discharging,
    output logic              pulse_done,
    output logic              open_circuit,
    output logic [1:0]        state_out,
    output logic [PCNT_W-1:0] pulse_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ON   = 2'd2,
        ST_OFF  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PCNT_W-1:0] PCNT_ONE = {{(PCNT_W-1){1'b0}}, 1'b1};

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   timer_r, timer_nxt_s;
    logic [CNT_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
    logic [CNT_W-1:0]   off_cnt_r, off_cnt_nxt_s;
    logic [CNT_W-1:0]   ton_r, ton_nxt_s;
    logic [CNT_W-1:0]   toff_r, toff_nxt_s;
    logic [CNT_W-1:0]   tmo_r, tmo_nxt_s;
    logic [PCNT_W-1:0]  pulse_count_r, pulse_count_nxt_s;
    logic               pulse_done_r, pulse_done_nxt_s;
    logic               open_circuit_r, open_circuit_nxt_s;
    logic               is_discharging_r, is_discharging_nxt_s;

    // Next-state, counter and strobe computation; outputs follow the next state
    always_comb begin
        state_nxt_s          = state_r;
        timer_nxt_s          = timer_r;
        wait_cnt_nxt_s       = wait_cnt_r;
        off_cnt_nxt_s        = off_cnt_r;
        ton_nxt_s            = ton_r;
        toff_nxt_s           = toff_r;
        tmo_nxt_s            = tmo_r;
        pulse_count_nxt_s    = pulse_count_r;
        pulse_done_nxt_s     = 1'b0;
        open_circuit_nxt_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                timer_nxt_s = CNT_ZERO;
                if (enable && (Ton_timer != CNT_ZERO)) begin
                    // Timing inputs are frozen here for the whole pulse
                    state_nxt_s    = ST_WAIT;
                    wait_cnt_nxt_s = CNT_ZERO;
                    ton_nxt_s      = Ton_timer;
                    toff_nxt_s     = (Toff_timer == CNT_ZERO) ? CNT_ONE : Toff_timer;
                    tmo_nxt_s      = wait_timeout;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (breakdown) begin
                    // Breakdown outranks a timeout falling in the same cycle
                    state_nxt_s = ST_ON;
                    timer_nxt_s = CNT_ONE;
                end else if ((tmo_r != CNT_ZERO) && (wait_cnt_r == (tmo_r - CNT_ONE))) begin
                    state_nxt_s        = ST_OFF;
                    off_cnt_nxt_s      = CNT_ZERO;
                    open_circuit_nxt_s = 1'b1;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
                end
            end
            ST_ON: begin
                if (!enable) begin
                    // Aborted pulse: still pay the off-time, but it does not count
                    state_nxt_s   = ST_OFF;
                    timer_nxt_s   = CNT_ZERO;
                    off_cnt_nxt_s = CNT_ZERO;
                end else if (timer_r == ton_r) begin
                    state_nxt_s       = ST_OFF;
                    timer_nxt_s       = CNT_ZERO;
                    off_cnt_nxt_s     = CNT_ZERO;
                    pulse_done_nxt_s  = 1'b1;
                    pulse_count_nxt_s = pulse_count_r + PCNT_ONE;
                end else begin
                    timer_nxt_s = timer_r + CNT_ONE;
                end
            end
            ST_OFF: begin
                timer_nxt_s = CNT_ZERO;
                if (off_cnt_r == (toff_r - CNT_ONE)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    off_cnt_nxt_s = off_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = CNT_ZERO;
            end
        endcase

        is_discharging_nxt_s = (state_nxt_s == ST_ON);
    end

    // State, counters, latched limits and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            timer_r          <= CNT_ZERO;
            wait_cnt_r       <= CNT_ZERO;
            off_cnt_r        <= CNT_ZERO;
            ton_r            <= CNT_ZERO;
            toff_r           <= CNT_ZERO;
            tmo_r            <= CNT_ZERO;
            pulse_count_r    <= {PCNT_W{1'b0}};
            pulse_done_r     <= 1'b0;
            open_circuit_r   <= 1'b0;
            is_discharging_r <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            timer_r          <= timer_nxt_s;
            wait_cnt_r       <= wait_cnt_nxt_s;
            off_cnt_r        <= off_cnt_nxt_s;
            ton_r            <= ton_nxt_s;
            toff_r           <= toff_nxt_s;
            tmo_r            <= tmo_nxt_s;
            pulse_count_r    <= pulse_count_nxt_s;
            pulse_done_r     <= pulse_done_nxt_s;
            open_circuit_r   <= open_circuit_nxt_s;
            is_discharging_r <= is_discharging_nxt_s;
        end
    end

    assign timer_buck_interleave = timer_r;
    assign is_discharging        = is_discharging_r;
    assign pulse_done            = pulse_done_r;
    assign open_circuit          = open_circuit_r;
    assign state_out             = state_r;
    assign pulse_count           = pulse_count_r;

endmodule
